// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizes for the RiSC-16 register file with scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through on reads).
package regfile_sb_pkg;

  // Default data width and register address width
  localparam int RF_WORD_LEN = 16;
  localparam int RF_ADDR_LEN = 3;

  // Sweep FSM encodings: clearing the array, or serving the pipeline
  typedef enum logic {
    RF_ST_INIT  = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Optional feature macro: REGFILE_BYPASS_EN (affects the slave only).
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int WORD_LEN = RF_WORD_LEN,
  parameter int ADDR_LEN = RF_ADDR_LEN,
  parameter int NUM_RD   = 2
);

  logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
  logic [NUM_RD*WORD_LEN-1:0] rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_LEN-1:0]        wr_addr;
  logic [WORD_LEN-1:0]        wr_data;
  logic                       rsv_en;
  logic [ADDR_LEN-1:0]        rsv_addr;
  logic                       clr_all;
  logic                       ready;
  logic                       rsv_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_all,
    input  rd_data, rd_busy, ready, rsv_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_all,
    output rd_data, rd_busy, ready, rsv_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set at issue, cleared at writeback.
// A reserve and a clear of the same register in one cycle leave the bit set.
// rsv_err is sticky and only returns to 0 on reset (flush keeps it).
module regfile_scoreboard #(
  parameter int ADDR_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [ADDR_LEN-1:0]      set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_LEN-1:0]      clr_addr,
  output logic [(2**ADDR_LEN)-1:0] busy,
  output logic                     rsv_err
);

  localparam int DEPTH = 2**ADDR_LEN;

  logic [DEPTH-1:0] busy_next;
  logic             err_set;

  // Next busy vector: flush wipes everything, otherwise clear first so a set wins
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (clr_en) busy_next[clr_addr] = 1'b0;
      if (set_en) busy_next[set_addr] = 1'b1;
    end
  end

  // Double reservation, unless a write to that register releases it this same cycle
  always_comb begin
    err_set = set_en && busy[set_addr] && !(clr_en && (clr_addr == set_addr));
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Sticky reservation-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rsv_err <= 1'b0;
    else if (err_set) rsv_err <= 1'b1;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, one write port and a busy scoreboard.
// The array has no per-entry reset; a sweep FSM zeroes R1..R(DEPTH-1) after reset
// or on clr_all, so the storage can map to distributed RAM.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write data/busy-clear on reads.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WORD_LEN = RF_WORD_LEN,
  parameter int ADDR_LEN = RF_ADDR_LEN,
  parameter int NUM_RD   = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int                  DEPTH    = 2**ADDR_LEN;
  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(DEPTH - 1);
  localparam logic [ADDR_LEN-1:0] FIRST_IDX = ADDR_LEN'(1);

  rf_state_e           state;
  rf_state_e           state_next;
  logic [ADDR_LEN-1:0] idx;
  logic                ready_int;
  logic                wr_ok;
  logic                rsv_ok;
  logic                flush;
  logic [DEPTH-1:0]    busy;
  logic                rsv_err_int;
  logic [WORD_LEN-1:0] mem [DEPTH];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RF_ST_INIT;
    else        state <= state_next;
  end

  // FSM next state: sweep until the last entry is cleared, re-sweep on clr_all
  always_comb begin
    state_next = state;
    case (state)
      RF_ST_INIT:  if (idx == LAST_IDX) state_next = RF_ST_READY;
      RF_ST_READY: if (bus.clr_all)     state_next = RF_ST_INIT;
      default:                          state_next = RF_ST_INIT;
    endcase
  end

  // FSM outputs: qualified write/reserve/flush strobes; R0 traffic is dropped
  always_comb begin
    ready_int = (state == RF_ST_READY);
    wr_ok     = ready_int && bus.wr_en  && (bus.wr_addr  != '0);
    rsv_ok    = ready_int && bus.rsv_en && (bus.rsv_addr != '0);
    flush     = ready_int && bus.clr_all;
  end

  // Sweep index: walks R1..R(DEPTH-1) in INIT, parked at R1 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   idx <= FIRST_IDX;
    else if (state == RF_ST_INIT) idx <= idx + FIRST_IDX;
    else                          idx <= FIRST_IDX;
  end

  // Array write: sweep zeroes have the port during INIT, writeback otherwise
  always_ff @(posedge clk) begin
    if (state == RF_ST_INIT) mem[idx] <= '0;
    else if (wr_ok)          mem[bus.wr_addr] <= bus.wr_data;
  end

  regfile_scoreboard #(
    .ADDR_LEN (ADDR_LEN)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (rsv_ok),
    .set_addr (bus.rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (bus.wr_addr),
    .busy     (busy),
    .rsv_err  (rsv_err_int)
  );

  assign bus.ready   = ready_int;
  assign bus.rsv_err = rsv_err_int;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_LEN-1:0] rd_a;
      logic [WORD_LEN-1:0] rd_d;
      logic                rd_b;

      assign rd_a = bus.rd_addr[gi*ADDR_LEN +: ADDR_LEN];

      // Read mux: zero during the sweep and for R0, array/busy otherwise
      always_comb begin
        rd_d = '0;
        rd_b = 1'b0;
        if (ready_int && (rd_a != '0)) begin
          rd_d = mem[rd_a];
          rd_b = busy[rd_a];
`ifdef REGFILE_BYPASS_EN
          if (wr_ok && (bus.wr_addr == rd_a)) begin
            rd_d = bus.wr_data;
            rd_b = 1'b0;
          end
`endif
        end
      end

      assign bus.rd_data[gi*WORD_LEN +: WORD_LEN] = rd_d;
      assign bus.rd_busy[gi]                      = rd_b;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (two read ports, default sizes).
// Table vectors go through a scoreboard queue; sweep, bypass and reset
// corners are hand-written sequences. Build with +define+REGFILE_BYPASS_EN
// to check the write-through variant.
module tb_regfile_sb;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb_if #(.WORD_LEN(16), .ADDR_LEN(3), .NUM_RD(2)) bus ();

  regfile_sb #(.WORD_LEN(16), .ADDR_LEN(3), .NUM_RD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  ra;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [15:0] d0;
    logic        b0;
    logic [15:0] d1;
    logic        b1;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] d0;
    logic        b0;
    logic [15:0] d1;
    logic        b1;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 16'h0000;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = 3'd0;
    bus.clr_all  = 1'b0;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready low at the current sample point and 6 more, high at the 8th
  task automatic check_sweep(input string tag);
    chk({tag, "_ready0_c0"}, 32'(bus.ready), 32'd0);
    for (int c = 1; c < 7; c++) begin
      step();
      chk($sformatf("%s_ready0_c%0d", tag, c), 32'(bus.ready), 32'd0);
    end
    step();
    chk({tag, "_ready1"}, 32'(bus.ready), 32'd1);
    $display("sweep %s: ready rose after 7 cycles", tag);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    exp_t e;
    bus.wr_en    = v.we;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.rsv_en   = v.re;
    bus.rsv_addr = v.ra;
    set_rd(v.a0, v.a1);
    exp_q.push_back('{v.d0, v.b0, v.d1, v.b1, v.err});
    step();
    idle_inputs();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vec%0d_queue: got empty required one entry", i);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_d0", i),  32'(bus.rd_data[15:0]),  32'(e.d0));
      chk($sformatf("vec%0d_b0", i),  32'(bus.rd_busy[0]),     32'(e.b0));
      chk($sformatf("vec%0d_d1", i),  32'(bus.rd_data[31:16]), 32'(e.d1));
      chk($sformatf("vec%0d_b1", i),  32'(bus.rd_busy[1]),     32'(e.b1));
      chk($sformatf("vec%0d_err", i), 32'(bus.rsv_err),        32'(e.err));
    end
    $display("vec %0d: we=%0b wa=%0d wd=%h re=%0b ra=%0d rd0[%0d]=%h/%0b rd1[%0d]=%h/%0b err=%0b",
             i, v.we, v.wa, v.wd, v.re, v.ra, v.a0, bus.rd_data[15:0], bus.rd_busy[0],
             v.a1, bus.rd_data[31:16], bus.rd_busy[1], bus.rsv_err);
  endtask

  initial begin
    logic [15:0] exp_bp_d;
    logic        exp_bp_b;

    //           we   wa    wd        re   ra    a0    a1    d0        b0    d1        b1    err
    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 3'd2, 3'd3, 16'h00AA, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd2, 16'h0000, 1'b0, 16'h00AA, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 16'h0055, 1'b1, 3'd2, 3'd2, 3'd2, 16'h0055, 1'b1, 16'h0055, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd2, 16'h0066, 1'b0, 3'd0, 3'd2, 3'd5, 16'h0066, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd5, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd3, 16'h1234, 1'b0, 16'hBEEF, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 3'd7, 3'd1, 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 3'd1, 3'd4, 16'h0000, 1'b1, 16'h4444, 1'b0, 1'b1};

    idle_inputs();
    set_rd(3'd1, 3'd2);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   32'(bus.ready),   32'd0);
    chk("rst_err",     32'(bus.rsv_err), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_busy", 32'(bus.rd_busy), 32'd0);

    // Initial sweep, then every register reads zero and idle
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("init");
    for (int a = 0; a < 8; a++) begin
      set_rd(3'(a), 3'(7 - a));
      #1;
      chk($sformatf("clean_d0_r%0d", a), 32'(bus.rd_data), 32'd0);
      chk($sformatf("clean_b_r%0d", a),  32'(bus.rd_busy), 32'd0);
    end

    // Table vectors
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Same-cycle visibility of a write to R6 (not busy)
`ifdef REGFILE_BYPASS_EN
    exp_bp_d = 16'h6666;
`else
    exp_bp_d = 16'h0000;
`endif
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'h6666;
    set_rd(3'd6, 3'd6);
    #1;
    chk("bypass_r6_same_cycle", 32'(bus.rd_data[15:0]), 32'(exp_bp_d));
    step();
    idle_inputs();
    chk("bypass_r6_next_cycle", 32'(bus.rd_data[15:0]), 32'h6666);
    $display("bypass R6: write 6666, same-cycle required %h", exp_bp_d);

    // Same-cycle busy release of R1 (reserved by the last vector)
`ifdef REGFILE_BYPASS_EN
    exp_bp_d = 16'h1111;
    exp_bp_b = 1'b0;
`else
    exp_bp_d = 16'h0000;
    exp_bp_b = 1'b1;
`endif
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 16'h1111;
    set_rd(3'd1, 3'd1);
    #1;
    chk("bypass_r1_data_same", 32'(bus.rd_data[15:0]), 32'(exp_bp_d));
    chk("bypass_r1_busy_same", 32'(bus.rd_busy[0]),    32'(exp_bp_b));
    step();
    idle_inputs();
    chk("bypass_r1_data_next", 32'(bus.rd_data[15:0]), 32'h1111);
    chk("bypass_r1_busy_next", 32'(bus.rd_busy[0]),    32'd0);
    $display("bypass R1: write 1111, same-cycle required %h/%0b", exp_bp_d, exp_bp_b);

    // Re-reserve R1, then clr_all: sweep ignores traffic, flushes busy, keeps rsv_err
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd1;
    step();
    idle_inputs();
    bus.clr_all = 1'b1;
    set_rd(3'd7, 3'd1);
    step();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 16'hAAAA;
    bus.rsv_en = 1'b1; bus.rsv_addr = 3'd3;
    chk("clr_c0_ready", 32'(bus.ready),          32'd0);
    chk("clr_c0_d0",    32'(bus.rd_data[15:0]),  32'd0);
    chk("clr_c0_b1",    32'(bus.rd_busy[1]),     32'd0);
    for (int c = 1; c < 7; c++) begin
      step();
      chk($sformatf("clr_c%0d_ready", c), 32'(bus.ready), 32'd0);
    end
    idle_inputs();
    step();
    chk("clr_ready1",  32'(bus.ready),         32'd1);
    chk("clr_r7_zero", 32'(bus.rd_data[15:0]), 32'd0);
    chk("clr_r1_free", 32'(bus.rd_busy[1]),    32'd0);
    chk("clr_err_kept", 32'(bus.rsv_err),      32'd1);
    set_rd(3'd3, 3'd3);
    #1;
    chk("clr_r3_free", 32'(bus.rd_busy[0]), 32'd0);
    $display("clr_all: R7=%h busy=%b err=%0b after sweep", bus.rd_data[15:0], bus.rd_busy, bus.rsv_err);

    // Write R2, start a sweep, assert reset at sweep cycle 3
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h2222;
    step();
    idle_inputs();
    bus.clr_all = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midsweep_rst_ready", 32'(bus.ready),   32'd0);
    chk("midsweep_rst_err",   32'(bus.rsv_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_rd(3'd2, 3'd7);
    check_sweep("after_rst");
    chk("after_rst_r2", 32'(bus.rd_data), 32'd0);
    $display("mid-sweep reset: full sweep rerun, R2=%h", bus.rd_data[15:0]);

    // Reset while READY drops ready without waiting for a clock
    #2 rst_n = 1'b0;
    #1;
    chk("ready_rst_async", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
